// File: rtl/ttt_move_sequencer.sv
// Input-side controller for the tic-tac-toe board: conditions buttons, arbitrates presses,
// issues one tagged move per legal press. Optional per-turn forfeit timer: TTT_TURN_TIMEOUT_EN.
module ttt_move_sequencer #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_CYCLES  = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [8:0] btn,
    input  logic       start,
    input  logic [8:0] occupied,
    input  logic       game_over,
    output logic       move_valid,
    output logic [3:0] move_cell,
    output logic       move_player,
    input  logic       move_ready,
    output logic       new_game,
    output logic       curr_player,
    output logic       timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ARMED,
        S_ISSUE,
        S_RELEASE,
        S_DONE
    } state_t;

    state_t      state, state_n;
    logic [9:0]  sync1, sync2, stable;
    logic [15:0] db_cnt [10];
    logic        start_q;
    logic        start_rise;
    logic [8:0]  db_btn;
    logic [8:0]  cand;
    logic [3:0]  cand_idx;
    logic        latch_move;
    logic        accept;
    logic        tmo_fire;

    // Bit 9 carries start; bits 8:0 carry the cell buttons.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1   <= '0;
            sync2   <= '0;
            stable  <= '0;
            start_q <= 1'b0;
            for (int i = 0; i < 10; i++) db_cnt[i] <= '0;
        end else begin
            sync1   <= {start, btn};
            sync2   <= sync1;
            start_q <= stable[9];
            for (int i = 0; i < 10; i++) begin
                if (sync2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == 16'(DEBOUNCE_CYCLES)) begin
                    stable[i] <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 16'd1;
                end
            end
        end
    end

    assign db_btn     = stable[8:0];
    assign start_rise = stable[9] & ~start_q;
    assign cand       = db_btn & ~occupied;

    // Lowest free pressed cell wins.
    always_comb begin
        cand_idx = 4'd0;
        for (int i = 8; i >= 0; i--) begin
            if (cand[i]) cand_idx = 4'(i);
        end
    end

`ifdef TTT_TURN_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit;

    assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt <= '0;
        end else if (state != S_ARMED && state_n == S_ARMED) begin
            tmo_cnt <= '0;
        end else if (state == S_ARMED) begin
            tmo_cnt <= tmo_fire ? '0 : tmo_cnt + TW'(1);
        end
    end

    assign timeout = tmo_fire;
`else
    // Constant 0 for any legal TIMEOUT_CYCLES; keeps the parameter referenced.
    assign timeout = (TIMEOUT_CYCLES < 0);
`endif

    always_comb begin
        state_n    = state;
        latch_move = 1'b0;
        accept     = 1'b0;
        tmo_fire   = 1'b0;
        case (state)
            S_IDLE:  if (start_rise) state_n = S_CLEAR;
            S_CLEAR: state_n = S_ARMED;
            S_ARMED: begin
                if (start_rise) begin
                    state_n = S_CLEAR;
                end else if (game_over) begin
                    state_n = S_DONE;
                end else if (cand != 9'd0) begin
                    latch_move = 1'b1;
                    state_n    = S_ISSUE;
                end
`ifdef TTT_TURN_TIMEOUT_EN
                else if (tmo_hit) begin
                    tmo_fire = 1'b1;
                end
`endif
            end
            // A valid, once raised, is held until accepted regardless of start/game_over.
            S_ISSUE: begin
                if (move_ready) begin
                    accept  = 1'b1;
                    state_n = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (db_btn == 9'd0) state_n = game_over ? S_DONE : S_ARMED;
            end
            S_DONE:  if (start_rise) state_n = S_CLEAR;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            move_cell   <= 4'd0;
            move_player <= 1'b0;
            curr_player <= 1'b0;
        end else begin
            state <= state_n;
            if (latch_move) begin
                move_cell   <= cand_idx;
                move_player <= curr_player;
            end
            if (state == S_CLEAR) curr_player <= 1'b0;
            else if (accept || tmo_fire) curr_player <= ~curr_player;
        end
    end

    assign move_valid = (state == S_ISSUE);
    assign new_game   = (state == S_CLEAR);

endmodule

// File: tb/tb_ttt_move_sequencer.sv
// Bench for ttt_move_sequencer: scenario tasks with a press-level reference model and
// a scoreboard of expected {player, cell} moves.
module tb_ttt_move_sequencer;

    localparam int D   = 4;
    localparam int TMO = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic [8:0] btn;
    logic       start;
    logic [8:0] occupied;
    logic       game_over;
    logic       move_valid;
    logic [3:0] move_cell;
    logic       move_player;
    logic       move_ready;
    logic       new_game;
    logic       curr_player;
    logic       timeout;

    int errors = 0;
    int checks = 0;
    logic [4:0] exp_q[$];
    logic [4:0] obs_q[$];
    logic       pl;

    ttt_move_sequencer #(.DEBOUNCE_CYCLES(D), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .btn(btn), .start(start), .occupied(occupied),
        .game_over(game_over), .move_valid(move_valid), .move_cell(move_cell),
        .move_player(move_player), .move_ready(move_ready), .new_game(new_game),
        .curr_player(curr_player), .timeout(timeout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (move_valid && move_ready) obs_q.push_back({move_player, move_cell});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference rule: lowest-index pressed cell that is not occupied, -1 if none.
    function automatic int ref_cell(logic [8:0] mask, logic [8:0] occ);
        for (int i = 0; i < 9; i++) if (mask[i] && !occ[i]) return i;
        return -1;
    endfunction

    task automatic do_press(input logic [8:0] mask, input logic [8:0] occ,
                            input int rdy_delay, input int hold);
        occupied   = occ;
        btn        = mask;
        move_ready = (rdy_delay == 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (i == rdy_delay) move_ready = 1'b1;
        end
        btn = '0;
        repeat (D + 8) @(negedge clk);
    endtask

    task automatic model_press(input logic [8:0] mask, input logic [8:0] occ);
        int c;
        c = ref_cell(mask, occ);
        if (c >= 0) begin
            exp_q.push_back({pl, 4'(c)});
            pl = ~pl;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; btn = '0; start = 1'b0; occupied = '0; game_over = 1'b0; move_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks += 6;
        if (move_valid !== 1'b0)  begin errors++; $display("FAIL reset_valid: got %b want 0", move_valid); end
        if (move_cell !== 4'd0)   begin errors++; $display("FAIL reset_cell: got %0d want 0", move_cell); end
        if (move_player !== 1'b0) begin errors++; $display("FAIL reset_player: got %b want 0", move_player); end
        if (new_game !== 1'b0)    begin errors++; $display("FAIL reset_new_game: got %b want 0", new_game); end
        if (curr_player !== 1'b0) begin errors++; $display("FAIL reset_curr: got %b want 0", curr_player); end
        if (timeout !== 1'b0)     begin errors++; $display("FAIL reset_timeout: got %b want 0", timeout); end
        reset = 1'b0;
        pl = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_new_game();
        int ng = 0;
        int ng_k = -1;
        start = 1'b1;
        for (int k = 1; k <= 3 * D + 20; k++) begin
            @(negedge clk);
            if (new_game) begin
                ng++;
                if (ng_k < 0) ng_k = k;
            end
            if (ng_k > 0 && k == ng_k + 1) begin
                checks++;
                if (curr_player !== 1'b0) begin errors++; $display("FAIL new_game_curr: got %b want 0", curr_player); end
            end
            if (k == D + 3) start = 1'b0;
        end
        checks += 2;
        if (ng != 1) begin errors++; $display("FAIL new_game_count: got %0d pulses want 1", ng); end
        if (ng_k != D + 4) begin errors++; $display("FAIL new_game_latency: got cycle %0d want %0d", ng_k, D + 4); end
        pl = 1'b0;
    endtask

    task automatic test_single_press();
        logic [4:0] e, o;
        do_press(9'h010, 9'h000, 0, 50);
        model_press(9'h010, 9'h000);
        checks++;
        if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL single_count: got %0d moves want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL single_move: got p%0d c%0d want p%0d c%0d", o[4], o[3:0], e[4], e[3:0]); end
        end
        exp_q.delete(); obs_q.delete();
        checks++;
        if (curr_player !== pl) begin errors++; $display("FAIL single_curr: got %b want %b", curr_player, pl); end
    endtask

    task automatic test_priority();
        logic [4:0] e, o;
        do_press(9'h084, 9'h004, 2, 30);
        model_press(9'h084, 9'h004);
        do_press(9'h004, 9'h004, 0, 30);
        model_press(9'h004, 9'h004);
        checks++;
        if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL priority_count: got %0d moves want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL priority_move: got p%0d c%0d want p%0d c%0d", o[4], o[3:0], e[4], e[3:0]); end
        end
        exp_q.delete(); obs_q.delete();
        checks++;
        if (curr_player !== pl) begin errors++; $display("FAIL priority_curr: got %b want %b", curr_player, pl); end
    endtask

    task automatic test_bounce();
        int seen = 0;
        occupied = '0; move_ready = 1'b1;
        repeat (10) begin
            btn = 9'h001;
            repeat (D - 1) begin @(negedge clk); if (move_valid) seen++; end
            btn = '0;
            repeat (D + 2) begin @(negedge clk); if (move_valid) seen++; end
        end
        checks += 2;
        if (seen != 0) begin errors++; $display("FAIL bounce_valid: got %0d valid cycles want 0", seen); end
        if (obs_q.size() != 0) begin errors++; $display("FAIL bounce_moves: got %0d moves want 0", obs_q.size()); end
        obs_q.delete();
    endtask

    task automatic test_random();
        logic [8:0] mask, occ;
        logic [4:0] e, o;
        for (int n = 0; n < 12; n++) begin
            mask = 9'($urandom_range(0, 511));
            occ  = 9'($urandom_range(0, 511));
            do_press(mask, occ, $urandom_range(0, 12), 30);
            model_press(mask, occ);
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL random_count: got %0d moves want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL random_move: got p%0d c%0d want p%0d c%0d", o[4], o[3:0], e[4], e[3:0]); end
        end
        exp_q.delete(); obs_q.delete();
        checks++;
        if (curr_player !== pl) begin errors++; $display("FAIL random_curr: got %b want %b", curr_player, pl); end
    endtask

    task automatic test_stall();
        logic [3:0] c;
        logic [4:0] e, o;
        int found = 0;
        int bad = 0;
        c = 4'($urandom_range(0, 8));
        occupied = '0; move_ready = 1'b0; btn = 9'(1) << c;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (move_valid) found = 1;
        end
        checks += 2;
        if (!found) begin errors++; $display("FAIL stall_valid_wait: no move_valid within 40 cycles"); end
        if ({move_player, move_cell} !== {pl, c}) begin
            errors++; $display("FAIL stall_offer: got p%0d c%0d want p%0d c%0d", move_player, move_cell, pl, c);
        end
        for (int k = 0; k < 20; k++) begin
            start = 1'($urandom_range(0, 1)); game_over = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (move_valid !== 1'b1 || move_cell !== c || move_player !== pl) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL stall_hold: %0d unstable cycles want 0", bad); end
        start = 1'b0; game_over = 1'b1; move_ready = 1'b1;
        @(negedge clk);
        btn = '0;
        repeat (D + 8) @(negedge clk);
        exp_q.push_back({pl, c});
        pl = ~pl;
        checks++;
        if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL stall_count: got %0d moves want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL stall_move: got p%0d c%0d want p%0d c%0d", o[4], o[3:0], e[4], e[3:0]); end
        end
        exp_q.delete(); obs_q.delete();
        checks++;
        if (curr_player !== pl) begin errors++; $display("FAIL stall_curr: got %b want %b", curr_player, pl); end
    endtask

    task automatic test_done();
        int seen = 0;
        int ng = 0;
        occupied = '0; move_ready = 1'b1; btn = 9'h020;
        repeat (30) begin @(negedge clk); if (move_valid) seen++; end
        btn = '0;
        repeat (D + 8) begin @(negedge clk); if (move_valid) seen++; end
        checks += 2;
        if (seen != 0) begin errors++; $display("FAIL done_valid: got %0d valid cycles want 0", seen); end
        if (obs_q.size() != 0) begin errors++; $display("FAIL done_moves: got %0d moves want 0", obs_q.size()); end
        obs_q.delete();
        game_over = 1'b0; start = 1'b1;
        for (int k = 1; k <= 3 * D + 12; k++) begin
            @(negedge clk);
            if (new_game) ng++;
            if (k == D + 3) start = 1'b0;
        end
        checks += 2;
        if (ng != 1) begin errors++; $display("FAIL done_restart: got %0d new_game pulses want 1", ng); end
        if (curr_player !== 1'b0) begin errors++; $display("FAIL done_curr: got %b want 0", curr_player); end
        pl = 1'b0;
    endtask

    task automatic test_reset_in_issue();
        int found = 0;
        occupied = '0; move_ready = 1'b0; btn = 9'h008;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (move_valid) found = 1;
        end
        reset = 1'b1;
        @(negedge clk);
        checks += 4;
        if (!found) begin errors++; $display("FAIL rst_issue_wait: no move_valid within 40 cycles"); end
        if (move_valid !== 1'b0) begin errors++; $display("FAIL rst_issue_valid: got %b want 0", move_valid); end
        if (move_cell !== 4'd0)  begin errors++; $display("FAIL rst_issue_cell: got %0d want 0", move_cell); end
        if (obs_q.size() != 0)   begin errors++; $display("FAIL rst_issue_moves: got %0d moves want 0", obs_q.size()); end
        obs_q.delete();
        btn = '0; reset = 1'b0; pl = 1'b0;
        repeat (D + 8) @(negedge clk);
    endtask

    task automatic test_timeout();
        int found = 0;
        logic exp_t, exp_p;
        bit en;
`ifdef TTT_TURN_TIMEOUT_EN
        en = 1'b1;
`else
        en = 1'b0;
`endif
        btn = '0; game_over = 1'b0; start = 1'b1;
        repeat (D + 3) @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            if (new_game) found = 1;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL timeout_start: no new_game seen"); end
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            exp_t = en && (k % TMO == 0);
            exp_p = en ? 1'(((k - 1) / TMO) % 2) : 1'b0;
            checks += 2;
            if (timeout !== exp_t) begin errors++; $display("FAIL timeout_pulse: cycle %0d got %b want %b", k, timeout, exp_t); end
            if (curr_player !== exp_p) begin errors++; $display("FAIL timeout_curr: cycle %0d got %b want %b", k, curr_player, exp_p); end
        end
    endtask

    initial begin
        test_reset();
        test_new_game();
`ifndef TTT_TURN_TIMEOUT_EN
        test_single_press();
        test_priority();
        test_bounce();
        test_random();
        test_stall();
        test_done();
        test_reset_in_issue();
`endif
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
